// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and helpers for the serial program loader.
//   state_t  - loader FSM states
//   mode_t   - encodings driven on the target's mode pins
//   frame_w  - serial frame length: address + data + one pad bit
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    GAP  = 3'd2,
    RUN  = 3'd3,
    FIN  = 3'd4
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_IDLE  = 2'b00;
  localparam mode_t MODE_SHIFT = 2'b01;
  localparam mode_t MODE_RUN   = 2'b11;

  function automatic int frame_w(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

endpackage

// File: rtl/prog_loader_start_debounce.sv
// start_debounce: 3-sample filter for the start request.
//   clk, rst : system clock, synchronous active-high reset
//   in       : raw start level
//   out      : filtered level, high only after 3 consecutive high samples
module start_debounce (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic [1:0] hist_q, hist_d;
  logic       out_q, out_d;

  always_comb begin
    hist_d = {hist_q[0], in};
    // Current sample plus the two previous ones must all be high.
    out_d  = &{hist_q, in};
  end

  // Reset to "high" so a start held across reset never looks like a new
  // rising edge downstream; a low input clears it after one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
      out_q  <= 1'b1;
    end else begin
      hist_q <= hist_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the demo processor.
// Holds a DEPTH-word image written through the host port. A rising edge on
// start shifts N words to the target as LSB-first frames {pad, data, addr}
// on sclk_out/mosi_out, then drives mode_out to run and waits for done_in.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   start              level request, rising edge starts a load
//   abort              return to IDLE next cycle from any state
//   num_words          words to send (0 or > DEPTH means DEPTH)
//   wr_en/addr/data    host image write, accepted in IDLE and FIN only
//   done_in            target finished executing
//   sclk_out/mosi_out  serial clock / data to target (sampled on sclk rise)
//   rst_n_out          ~rst to the target
//   mode_out           00 idle/gap, 01 shifting, 11 run
//   busy, done         busy outside IDLE/FIN, done while in FIN
//
// Build option: define PROG_LOADER_DEBOUNCE_EN to filter start through
// start_debounce (3 extra cycles of start latency).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 1,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_words,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              done_in,
  output logic              sclk_out,
  output logic              mosi_out,
  output logic              rst_n_out,
  output logic [1:0]        mode_out,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  // ---------------------------------------------------------------------
  // Start conditioning
  // ---------------------------------------------------------------------
  logic start_f;

`ifdef PROG_LOADER_DEBOUNCE_EN
  start_debounce u_start_db (
    .clk (clk),
    .rst (rst),
    .in  (start),
    .out (start_f)
  );
`else
  assign start_f = start;
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              start_prev_q, start_prev_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;

  logic [DATA_W-1:0] img_q [DEPTH];

  logic               start_rise;
  logic               tick;
  logic               img_we;
  logic               last_word;
  logic [ADDR_W:0]    n_eff;
  logic [BIT_W-1:0]   bit_nx;
  logic [ADDR_W-1:0]  word_nx;
  logic [FRAME_W-1:0] frame_cur;

  assign start_rise = start_f & ~start_prev_q;
  assign tick       = (div_q == DIV_LAST);
  assign n_eff      = (num_words == '0 || num_words > DEPTH_L) ? DEPTH_L : num_words;
  assign bit_nx     = bit_q + 1'b1;
  assign word_nx    = word_q + 1'b1;
  assign last_word  = ({1'b0, word_q} == n_q - 1'b1);
  // Image is read live, so a write landing on the start edge is still sent.
  assign frame_cur  = {1'b0, img_q[word_q], word_q};
  assign img_we     = wr_en && (state_q == IDLE || state_q == FIN) &&
                      ({1'b0, wr_addr} < DEPTH_L);

  always_comb begin
    state_d      = state_q;
    start_prev_d = start_f;
    div_d        = div_q;
    gap_d        = gap_q;
    bit_d        = bit_q;
    word_d       = word_q;
    n_d          = n_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (start_rise) begin
          state_d = SEND;
          n_d     = n_eff;
          word_d  = '0;
          bit_d   = '0;
          div_d   = '0;
          // Frame bit 0 is the address LSB, which is 0 for word 0.
          mosi_d  = 1'b0;
        end
      end

      SEND: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // Falling tick: advance to the next bit or close the frame.
            if (bit_q == LAST_BIT) begin
              state_d = GAP;
              gap_d   = '0;
              sclk_d  = 1'b0;
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_nx;
              mosi_d = frame_cur[bit_nx];
            end
          end
        end
      end

      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (last_word) begin
            state_d = RUN;
          end else begin
            state_d = SEND;
            word_d  = word_nx;
            bit_d   = '0;
            div_d   = '0;
            mosi_d  = word_nx[0];
          end
        end
      end

      RUN: begin
        if (done_in) state_d = FIN;
      end

      FIN: begin
        if (!start_f) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      div_d   = '0;
      gap_d   = '0;
      bit_d   = '0;
      word_d  = '0;
      n_d     = '0;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      // Treat start as already high so a level held across reset is ignored.
      start_prev_q <= 1'b1;
      div_q        <= '0;
      gap_q        <= '0;
      bit_q        <= '0;
      word_q       <= '0;
      n_q          <= '0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      bit_q        <= bit_d;
      word_q       <= word_d;
      n_q          <= n_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (img_we) img_q[wr_addr] <= wr_data;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    mode_out = MODE_IDLE;
    case (state_q)
      SEND:    mode_out = MODE_SHIFT;
      RUN:     mode_out = MODE_RUN;
      default: mode_out = MODE_IDLE;
    endcase
  end

  assign sclk_out  = sclk_q;
  assign mosi_out  = mosi_q;
  assign rst_n_out = ~rst;
  assign busy      = (state_q != IDLE) && (state_q != FIN);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
// DUT a uses default parameters and carries the frame scoreboard; DUT b uses
// CLK_DIV=3, GAP_CYC=4 for sclk/gap timing checks.
module tb_prog_loader;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int DEP = 16;
  localparam int FW  = AW + DW + 1;
`ifdef PROG_LOADER_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start_b = 1'b0, abort = 1'b0, done_in = 1'b0;
  logic [AW:0] num_words = '0, num_words_b = '0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic sclk_out, mosi_out, rst_n_out, busy, done;
  logic [1:0] mode_out;
  logic sclk_b, mosi_b, rst_n_b, busy_b, done_b;
  logic [1:0] mode_b;

  always #5 clk = ~clk;

  prog_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .CLK_DIV(1), .GAP_CYC(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done_in(done_in),
    .sclk_out(sclk_out), .mosi_out(mosi_out), .rst_n_out(rst_n_out),
    .mode_out(mode_out), .busy(busy), .done(done)
  );

  prog_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .CLK_DIV(3), .GAP_CYC(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .num_words(num_words_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done_in(done_in),
    .sclk_out(sclk_b), .mosi_out(mosi_b), .rst_n_out(rst_n_b),
    .mode_out(mode_b), .busy(busy_b), .done(done_b)
  );

  // Frame capture on DUT a: sample mosi on each sclk rise while shifting.
  logic [FW-1:0] got_q [$];
  logic [FW-1:0] acc = '0;
  int            acc_n = 0;
  logic          sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (rst || mode_out !== 2'b01) begin
      acc_n = 0;
    end else if (sclk_out && !sclk_prev) begin
      acc   = {mosi_out, acc[FW-1:1]};
      acc_n = acc_n + 1;
      if (acc_n == FW) begin
        got_q.push_back(acc);
        acc_n = 0;
      end
    end
    sclk_prev = sclk_out;
  end

  // Scoreboard state
  int            n_vec = 0, n_miss = 0, got_rd = 0;
  logic [DW-1:0] img_m [DEP];
  logic [FW-1:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
    @(negedge clk);
    wr_en = 1'b0;
    img_m[a] = DW'(d);
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget, input string nm);
    int k = 0;
    while (mode_out !== m && k < budget) begin @(negedge clk); k++; end
    if (mode_out !== m) check(nm, mode_out, m);
  endtask

  task automatic push_frames(input int nw);
    int n = (nw == 0 || nw > DEP) ? DEP : nw;
    for (int w = 0; w < n; w++) exp_q.push_back({1'b0, img_m[w], AW'(w)});
  endtask

  task automatic drain(input string nm, input bit chk_missing);
    while (got_rd < got_q.size()) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL %s_extra: got frame %0h, expected none", nm, got_q[got_rd]);
      end else begin
        check(nm, got_q[got_rd], exp_q.pop_front());
      end
      got_rd++;
    end
    if (chk_missing) check({nm, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_to_run(input int nw, input string nm);
    num_words = (AW+1)'(nw);
    push_frames(nw);
    start = 1'b1;
    @(negedge clk);
    wait_mode(2'b11, 40*DEP + 100, {nm, "_run"});
  endtask

  task automatic finish_load(input string nm);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    check({nm, "_done"}, done, 1);
    start = 1'b0;
    tick_n(3);
    check({nm, "_idle"}, {busy, done}, 0);
  endtask

  typedef struct {
    int nw;
    bit wr;        // host write on the start edge
    int wa;
    int wd;
    bit wr_busy;   // host write while shifting (must be ignored)
    int exp_frames;
  } vec_t;

  vec_t vt [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, len, lo, hi, phase, gap, sbad, bad, base;

    vt[0] = '{3,  0, 0, 0,     0, 3};
    vt[1] = '{0,  0, 0, 0,     1, 16};
    vt[2] = '{20, 1, 5, 8'h5A, 0, 16};
    vt[3] = '{16, 0, 0, 0,     0, 16};
    vt[4] = '{1,  1, 0, 8'hC3, 0, 1};
    vt[5] = '{2,  0, 0, 0,     0, 2};

    // Reset, with start held high across it.
    start = 1'b1;
    tick_n(3);
    check("rst_n_out_low", rst_n_out, 0);
    check("rst_outs", {sclk_out, mosi_out, mode_out, busy, done}, 0);
    rst = 1'b0;
    #1;
    check("rst_n_out_high", rst_n_out, 1);
    tick_n(10);
    check("held_start_no_load", {busy, mode_out}, 0);
    start = 1'b0;
    tick_n(5);

    // Image fill.
    for (int a = 0; a < DEP; a++) host_wr(a, int'($urandom_range(0, 255)));
    host_wr(0, 8'hA5);
    host_wr(1, 8'h3C);
    host_wr(2, 8'hFF);

    // Table-driven loads.
    for (int i = 0; i < 6; i++) begin
      int lat;
      base = got_q.size();
      num_words = (AW+1)'(vt[i].nw);
      start = 1'b1;
      if (vt[i].wr) begin
        wr_en = 1'b1; wr_addr = AW'(vt[i].wa); wr_data = DW'(vt[i].wd);
        img_m[vt[i].wa] = DW'(vt[i].wd);
      end
      push_frames(vt[i].nw);
      @(negedge clk);
      wr_en = 1'b0;
      lat = 1;
      while (mode_out !== 2'b01 && lat < 20) begin @(negedge clk); lat++; end
      check("start_lat", lat, LAT);
      if (vt[i].wr_busy) begin
        tick_n(3);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = ~img_m[2];
        @(negedge clk);
        wr_en = 1'b0;
      end
      wait_mode(2'b11, 40*DEP + 100, "reach_run");
      tick_n(1);
      check("busy_run", busy, 1);
      check("frame_count", got_q.size() - base, vt[i].exp_frames);
      if (i == 0)
        check("frame1_literal", (got_q.size() > base + 1) ? got_q[base+1] : '1, 13'h03C1);
      drain("frame", 1'b1);
      done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      check("fin_outs", {mode_out, busy, done}, 4'b0001);
      start = 1'b0;
      tick_n(3);
      check("idle_outs", {mode_out, busy, done}, 0);
    end

    // Divided sclk and gap timing on DUT b.
    num_words_b = 1;
    start_b = 1'b1;
    k = 0;
    while (mode_b !== 2'b01 && k < 20) begin @(negedge clk); k++; end
    check("b_send", mode_b, 2'b01);
    len = 0; lo = 0; hi = 0; phase = 0;
    while (mode_b === 2'b01 && len < 200) begin
      len++;
      if (phase == 0) begin
        if (sclk_b) begin phase = 1; hi = 1; end else lo++;
      end else if (phase == 1) begin
        if (sclk_b) hi++; else phase = 2;
      end
      @(negedge clk);
    end
    check("b_frame_len", len, 78);
    check("b_sclk_low", lo, 3);
    check("b_sclk_high", hi, 3);
    gap = 0; sbad = 0;
    while (mode_b === 2'b00 && gap < 50) begin
      gap++;
      if (sclk_b) sbad++;
      @(negedge clk);
    end
    check("b_gap_len", gap, 4);
    check("b_gap_sclk", sbad, 0);
    check("b_run", mode_b, 2'b11);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    check("b_done", done_b, 1);
    start_b = 1'b0;
    tick_n(3);
    check("b_idle", {busy_b, done_b}, 0);

    // RUN handshake with a long wait for done_in.
    load_to_run(1, "hs");
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (mode_out !== 2'b11) bad++;
      @(negedge clk);
    end
    check("hs_mode_run", bad, 0);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    check("hs_fin", {mode_out, done}, 3'b001);
    tick_n(5);
    check("hs_fin_hold", {mode_out, busy, done}, 4'b0001);
    start = 1'b0;
    tick_n(3);
    check("hs_idle", {busy, done}, 0);
    drain("hs_frame", 1'b1);

    // done_in already high when RUN is entered.
    done_in = 1'b1;
    load_to_run(1, "early");
    @(negedge clk);
    check("early_fin", {mode_out, done}, 3'b001);
    done_in = 1'b0;
    start = 1'b0;
    tick_n(3);
    check("early_idle", done, 0);
    drain("early_frame", 1'b1);

    // Abort at bit 6 of word 1, then reload from word 0.
    num_words = 3;
    push_frames(3);
    start = 1'b1;
    @(negedge clk);
    wait_mode(2'b01, 20, "ab_f0");
    wait_mode(2'b00, 40, "ab_gap");
    wait_mode(2'b01, 10, "ab_f1");
    tick_n(12);
    abort = 1'b1;
    @(negedge clk);
    check("ab_outs", {sclk_out, mosi_out, mode_out, busy}, 0);
    abort = 1'b0;
    drain("ab_frame0", 1'b0);
    start = 1'b0;
    tick_n(3);
    check("ab_idle", {busy, mode_out}, 0);
    base = got_q.size();
    load_to_run(2, "reload");
    tick_n(1);
    check("reload_count", got_q.size() - base, 2);
    drain("reload_frame", 1'b1);
    finish_load("reload");

`ifdef PROG_LOADER_DEBOUNCE_EN
    // A 2-cycle start glitch must not start a load.
    start = 1'b1;
    tick_n(2);
    start = 1'b0;
    tick_n(10);
    check("glitch_no_load", {busy, mode_out}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
